priority_arbiter: RTL and testbench

// - Registered N-input arbiter built around a priority encoder; successor to the combinational encoder.
// - Adds fixed or round-robin priority, grant hold (blocking) modes and a one-hot + encoded grant.
// - Sits in front of shared resources: mux select, shared FIFO write port, shared bus master.

---
 rtl/priority_arbiter.sv | 168 ++++++++++++++++
 tb/tb_priority_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// Registered N-port arbiter: fixed or round-robin priority, NONE/REQUEST/ACKNOWLEDGE grant hold.
// Optional grant watchdog (grant_timeout port) enabled by defining PRIORITY_ARBITER_TIMEOUT_EN.
module priority_arbiter #(
   parameter int    PORTS          = 4,
   parameter string TYPE           = "PRIORITY",
   parameter string BLOCK          = "NONE",
   parameter string LSB_PRIORITY   = "LOW",
   parameter int    TIMEOUT_CYCLES = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PORTS-1:0]         request,
   input  logic [PORTS-1:0]         acknowledge,
   output logic [PORTS-1:0]         grant,
   output logic                     grant_valid,
   output logic [$clog2(PORTS)-1:0] grant_encoded
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
   ,
   output logic                     grant_timeout
`endif
);

   localparam int IDX_W       = $clog2(PORTS);
   localparam bit IS_RR       = (TYPE == "ROUND_ROBIN");
   localparam bit IS_LOW      = (LSB_PRIORITY == "LOW");
   localparam int BLK_NONE    = 0;
   localparam int BLK_REQUEST = 1;
   localparam int BLK_ACK     = 2;
   localparam int BLK_MODE    = (BLOCK == "REQUEST")     ? BLK_REQUEST :
                                (BLOCK == "ACKNOWLEDGE") ? BLK_ACK : BLK_NONE;
   localparam logic [IDX_W-1:0] FIXED_START = IS_LOW ? '0 : IDX_W'(PORTS - 1);
   localparam logic [PORTS-1:0] ONE_LSB     = {{(PORTS-1){1'b0}}, 1'b1};

   if (PORTS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("priority_arbiter: PORTS and TIMEOUT_CYCLES must both be >= 2");
   end

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_t;

   state_t             state_r, state_nxt_s;
   logic [PORTS-1:0]   grant_r, grant_nxt_s;
   logic [IDX_W-1:0]   enc_r, enc_nxt_s;
   logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
   logic               grant_valid_r;
   logic [IDX_W-1:0]   start_s, win_s;
   logic               found_s, held_req_s, held_ack_s;
   logic               release_s, timeout_s, arbitrate_s, take_s;

   // Walk from lowest to highest priority so the last hit is the winner; returns {found, index}.
   function automatic logic [IDX_W:0] pick_winner(input logic [PORTS-1:0] req,
                                                  input logic [IDX_W-1:0] start);
      logic             found;
      logic [IDX_W-1:0] win;
      logic [IDX_W-1:0] pos;
      int               raw;
      found = 1'b0;
      win   = '0;
      for (int k = PORTS - 1; k >= 0; k--) begin
         raw   = IS_LOW ? int'(start) + k : int'(start) - k + PORTS;
         raw   = (raw >= PORTS) ? raw - PORTS : raw;
         pos   = IDX_W'(raw);
         win   = req[pos] ? pos : win;
         found = found | req[pos];
      end
      return {found, win};
   endfunction

   // Index that follows idx in the priority direction, wrapping at PORTS.
   function automatic logic [IDX_W-1:0] step_index(input logic [IDX_W-1:0] idx);
      int n;
      n = IS_LOW ? int'(idx) + 1 : int'(idx) - 1 + PORTS;
      n = (n >= PORTS) ? n - PORTS : n;
      return IDX_W'(n);
   endfunction

`ifdef PRIORITY_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_r;
   logic             grant_timeout_r;

   // Watchdog: counts cycles the current grant has been held, cleared on every arbitration.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r           <= '0;
         grant_timeout_r <= 1'b0;
      end else begin
         cnt_r           <= arbitrate_s ? '0 : cnt_r + CNT_W'(1);
         grant_timeout_r <= timeout_s;
      end
   end

   assign grant_timeout = grant_timeout_r;
`endif

   // Next state: decide whether the held grant is released and whether arbitration happens.
   always_comb begin
      start_s            = IS_RR ? ptr_r : FIXED_START;
      {found_s, win_s}   = pick_winner(request, start_s);
      held_req_s         = |(request & grant_r);
      held_ack_s         = |(acknowledge & grant_r);
      release_s          = 1'b0;
      timeout_s          = 1'b0;
      case (state_r)
         ST_IDLE: begin
            release_s = 1'b0;
         end
         ST_GRANTED: begin
            case (BLK_MODE)
               BLK_REQUEST: release_s = ~held_req_s;
               BLK_ACK:     release_s = held_ack_s;
               default:     release_s = 1'b1;
            endcase
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
            timeout_s = ~release_s & (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
         end
         default: begin
            release_s = 1'b1;
         end
      endcase
      arbitrate_s = (state_r == ST_IDLE) | release_s | timeout_s;
      if (arbitrate_s) begin
         state_nxt_s = found_s ? ST_GRANTED : ST_IDLE;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Next outputs: a new grant moves the round-robin pointer past the winner; holds leave it alone.
   always_comb begin
      take_s = arbitrate_s & found_s;
      if (take_s) begin
         grant_nxt_s = ONE_LSB << win_s;
         enc_nxt_s   = win_s;
         ptr_nxt_s   = IS_RR ? step_index(win_s) : ptr_r;
      end else if (arbitrate_s) begin
         grant_nxt_s = '0;
         enc_nxt_s   = '0;
         ptr_nxt_s   = ptr_r;
      end else begin
         grant_nxt_s = grant_r;
         enc_nxt_s   = enc_r;
         ptr_nxt_s   = ptr_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         grant_r       <= '0;
         enc_r         <= '0;
         ptr_r         <= '0;
         grant_valid_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         grant_r       <= grant_nxt_s;
         enc_r         <= enc_nxt_s;
         ptr_r         <= ptr_nxt_s;
         grant_valid_r <= (state_nxt_s == ST_GRANTED);
      end
   end

   assign grant         = grant_r;
   assign grant_valid   = grant_valid_r;
   assign grant_encoded = enc_r;

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter: vector tables, corner sequences and a random run
// against a behavioural model. Define PRIORITY_ARBITER_TIMEOUT_EN to add the watchdog instance.
module tb_priority_arbiter;

`ifdef PRIORITY_ARBITER_TIMEOUT_EN
   localparam int NI    = 6;
   localparam bit TO_EN = 1'b1;
`else
   localparam int NI    = 5;
   localparam bit TO_EN = 1'b0;
`endif
   // Per-instance configuration seen by the model (block: 0 none, 1 request, 2 acknowledge).
   localparam int CFG_RR  [6] = '{0, 1, 1, 1, 0, 1};
   localparam int CFG_BLK [6] = '{0, 0, 2, 1, 2, 2};
   localparam int CFG_LOW [6] = '{1, 1, 1, 1, 0, 1};
   localparam int CFG_LIM [6] = '{256, 256, 256, 256, 256, 4};

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] rq   [NI];
   logic [3:0] ak   [NI];
   logic [3:0] gnt  [NI];
   logic       gv   [NI];
   logic [1:0] genc [NI];
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
   logic       gto  [NI];
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int m_valid [NI];
   int m_idx   [NI];
   int m_ptr   [NI];
   int m_held  [NI];
   bit m_to    [NI];

   always #5 clk = ~clk;

   priority_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_fix_none (
      .clk(clk), .rst(rst), .request(rq[0]), .acknowledge(ak[0]), .grant(gnt[0]),
      .grant_valid(gv[0]), .grant_encoded(genc[0])
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
      , .grant_timeout(gto[0])
`endif
   );

   priority_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_rr_none (
      .clk(clk), .rst(rst), .request(rq[1]), .acknowledge(ak[1]), .grant(gnt[1]),
      .grant_valid(gv[1]), .grant_encoded(genc[1])
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
      , .grant_timeout(gto[1])
`endif
   );

   priority_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW")) u_rr_ack (
      .clk(clk), .rst(rst), .request(rq[2]), .acknowledge(ak[2]), .grant(gnt[2]),
      .grant_valid(gv[2]), .grant_encoded(genc[2])
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
      , .grant_timeout(gto[2])
`endif
   );

   priority_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("REQUEST"), .LSB_PRIORITY("LOW")) u_rr_req (
      .clk(clk), .rst(rst), .request(rq[3]), .acknowledge(ak[3]), .grant(gnt[3]),
      .grant_valid(gv[3]), .grant_encoded(genc[3])
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
      , .grant_timeout(gto[3])
`endif
   );

   priority_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("HIGH")) u_fix_ack_hi (
      .clk(clk), .rst(rst), .request(rq[4]), .acknowledge(ak[4]), .grant(gnt[4]),
      .grant_valid(gv[4]), .grant_encoded(genc[4])
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
      , .grant_timeout(gto[4])
`endif
   );

`ifdef PRIORITY_ARBITER_TIMEOUT_EN
   priority_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW"),
                      .TIMEOUT_CYCLES(4)) u_rr_ack_to (
      .clk(clk), .rst(rst), .request(rq[5]), .acknowledge(ak[5]), .grant(gnt[5]),
      .grant_valid(gv[5]), .grant_encoded(genc[5]), .grant_timeout(gto[5])
   );
`endif

   function automatic logic act_to(input int i);
`ifdef PRIORITY_ARBITER_TIMEOUT_EN
      return gto[i];
`else
      return (i < 0);
`endif
   endfunction

   function automatic logic [31:0] pack(input logic [3:0] g, input logic [1:0] e, input logic v, input logic t);
      return {24'd0, g, e, v, t};
   endfunction

   function automatic logic [31:0] dut_word(input int i);
      return pack(gnt[i], genc[i], gv[i], act_to(i));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%02h required=0x%02h (grant,enc,valid,timeout)", name, act, exp);
      end
   endtask

   // Reference model: a grant is a port index plus a count of cycles it has been visible.
   function automatic void model_step(input int i);
      bit rel;
      bit to;
      int w;
      int p;
      if (rst) begin
         m_valid[i] = 0; m_idx[i] = 0; m_ptr[i] = 0; m_held[i] = 0; m_to[i] = 1'b0;
         return;
      end
      rel = 1'b0;
      to  = 1'b0;
      if (m_valid[i] != 0) begin
         if (CFG_BLK[i] == 0)      rel = 1'b1;
         else if (CFG_BLK[i] == 1) rel = !rq[i][m_idx[i]];
         else                      rel = ak[i][m_idx[i]];
         to = TO_EN && !rel && (m_held[i] >= CFG_LIM[i]);
      end
      m_to[i] = to;
      if (m_valid[i] != 0 && !rel && !to) begin
         m_held[i]++;
         return;
      end
      w = -1;
      for (int k = 0; k < 4; k++) begin
         if (CFG_RR[i] != 0) p = (CFG_LOW[i] != 0) ? (m_ptr[i] + k) % 4 : (m_ptr[i] - k + 4) % 4;
         else                p = (CFG_LOW[i] != 0) ? k : 3 - k;
         if (w < 0 && rq[i][p]) w = p;
      end
      if (w < 0) begin
         m_valid[i] = 0; m_idx[i] = 0; m_held[i] = 0;
      end else begin
         m_valid[i] = 1; m_idx[i] = w; m_held[i] = 1;
         m_ptr[i]   = (CFG_LOW[i] != 0) ? (w + 1) % 4 : (w + 3) % 4;
      end
   endfunction

   function automatic logic [31:0] model_word(input int i);
      logic [3:0] g;
      g = (m_valid[i] != 0) ? (4'b0001 << m_idx[i]) : 4'b0000;
      return pack(g, (m_valid[i] != 0) ? 2'(m_idx[i]) : 2'd0, m_valid[i] != 0, m_to[i]);
   endfunction

   // One clock: update the model at the edge, compare every instance on the falling edge.
   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < NI; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk($sformatf("model_u%0d", i), dut_word(i), model_word(i));
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < NI; i++) begin
         rq[i] = 4'b0000;
         ak[i] = 4'b0000;
      end
   endtask

   typedef struct {
      int         inst;
      logic [3:0] req;
      logic [3:0] ack;
      logic [3:0] exp_grant;
      logic [1:0] exp_enc;
      logic       exp_valid;
   } vec_t;

   vec_t vecs [$];

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         rq[i] = 4'b1111;
         ak[i] = 4'b0000;
      end

      // Fixed LOW, no hold.
      vecs.push_back('{0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1});
      vecs.push_back('{0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1});
      vecs.push_back('{0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
      vecs.push_back('{0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1});
      vecs.push_back('{0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1});
      vecs.push_back('{0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
      // Round-robin, all requesting: rotation 0,1,2,3,0,1,2,3.
      for (int k = 0; k < 8; k++)
         vecs.push_back('{1, 4'b1111, 4'b0000, 4'b0001 << (k % 4), 2'(k % 4), 1'b1});
      // Round-robin acknowledge hold.
      vecs.push_back('{2, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1});
      vecs.push_back('{2, 4'b0100, 4'b0000, 4'b0010, 2'd1, 1'b1});
      vecs.push_back('{2, 4'b0100, 4'b0100, 4'b0010, 2'd1, 1'b1});
      vecs.push_back('{2, 4'b0100, 4'b0010, 4'b0100, 2'd2, 1'b1});
      vecs.push_back('{2, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0});
      vecs.push_back('{2, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1});
      vecs.push_back('{2, 4'b0101, 4'b0001, 4'b0100, 2'd2, 1'b1});
      // Fixed HIGH acknowledge hold.
      vecs.push_back('{4, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1});
      vecs.push_back('{4, 4'b1011, 4'b0000, 4'b0010, 2'd1, 1'b1});
      vecs.push_back('{4, 4'b1011, 4'b0010, 4'b1000, 2'd3, 1'b1});
      vecs.push_back('{4, 4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1});
      vecs.push_back('{4, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0});

      // Reset with every port requesting.
      for (int c = 0; c < 3; c++) begin
         cycle();
         for (int i = 0; i < NI; i++) chk($sformatf("reset_u%0d", i), dut_word(i), 32'd0);
      end
      rst = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         clear_inputs();
         rq[vecs[k].inst] = vecs[k].req;
         ak[vecs[k].inst] = vecs[k].ack;
         cycle();
         chk($sformatf("vec%0d_u%0d", k, vecs[k].inst), dut_word(vecs[k].inst),
             pack(vecs[k].exp_grant, vecs[k].exp_enc, vecs[k].exp_valid, 1'b0));
      end

      // Request hold, drop with same-cycle re-arbitration, then reset mid-grant.
      clear_inputs();
      rq[3] = 4'b1000; cycle(); chk("req_grant3", dut_word(3), pack(4'b1000, 2'd3, 1'b1, 1'b0));
      rq[3] = 4'b1010; cycle(); chk("req_hold3",  dut_word(3), pack(4'b1000, 2'd3, 1'b1, 1'b0));
      rq[3] = 4'b0010; cycle(); chk("req_drop3",  dut_word(3), pack(4'b0010, 2'd1, 1'b1, 1'b0));
      rst = 1'b1; rq[3] = 4'b1111;
      cycle(); chk("req_rst", dut_word(3), 32'd0);
      rst = 1'b0;
      cycle(); chk("req_ptr_restart", dut_word(3), pack(4'b0001, 2'd0, 1'b1, 1'b0));

`ifdef PRIORITY_ARBITER_TIMEOUT_EN
      // Watchdog: no acknowledge, grant forced off after 4 held cycles.
      clear_inputs();
      rq[5] = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         cycle(); chk($sformatf("to_hold%0d", c), dut_word(5), pack(4'b0001, 2'd0, 1'b1, 1'b0));
      end
      cycle(); chk("to_pulse", dut_word(5), pack(4'b0010, 2'd1, 1'b1, 1'b1));
      cycle(); chk("to_after", dut_word(5), pack(4'b0010, 2'd1, 1'b1, 1'b0));
`endif

      // Random run against the model; requests persist a few cycles so holds are exercised.
      clear_inputs();
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < NI; i++) begin
            if ($urandom_range(0, 3) == 0) rq[i] = 4'($urandom_range(0, 15));
            ak[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
